// File: rtl/fifo_mem_pkg.sv
// Shared sizing helpers for the fifo_mem block.
// Pointer and occupancy widths are derived from DEPTH.
package fifo_mem_pkg;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so the count can hold DEPTH itself.
    function automatic int cnt_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_ram.sv
// Simple dual-port RAM: one synchronous write port and one synchronous read port with enable.
// Storage has no reset.
module fifo_mem_ram
    import fifo_mem_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ptr_width(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         re,
    input  logic [ptr_width(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]             rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A read of the address being written this edge returns the old contents.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_mem.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Pointers, occupancy count and flags live here; storage is in fifo_mem_ram.
module fifo_mem
    import fifo_mem_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_mem: DEPTH must be a power of two and at least 2");
    end

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             wr_ok;
    logic             rd_ok;
    logic             read_seen;
    logic [WIDTH-1:0] ram_q;

    // A write into a full FIFO is allowed when a read frees a slot on the same edge.
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            read_seen <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (rd_ok) begin
                rptr      <= rptr + PW'(1);
                read_seen <= 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The RAM output register has no reset, so present zero until the first read after reset.
    assign rd_data = read_seen ? ram_q : '0;

    fifo_mem_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr),
        .wdata (wr_data),
        .re    (rd_ok),
        .raddr (rptr),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_fifo_mem.sv
// Directed self-checking bench for fifo_mem (WIDTH=4, DEPTH=8).
module tb_fifo_mem;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [3:0] wr_data;
    logic       full;
    logic       rd_en;
    logic [3:0] rd_data;
    logic       empty;

    int tests;
    int failures;

    fifo_mem #(
        .WIDTH (4),
        .DEPTH (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic w, input logic [3:0] d, input logic r);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] q[$];
        logic [3:0] exp_word;
        logic [3:0] five_words [5];
        logic       w;
        logic       r;
        logic [3:0] d;

        tests    = 0;
        failures = 0;
        five_words = '{4'h3, 4'h9, 4'hA, 4'h1, 4'hF};

        reset   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 4'h0;
        #1;
        check("reset_async_empty", empty, 4'h1);
        repeat (2) @(posedge clk);
        #1;
        check("reset_empty", empty, 4'h1);
        check("reset_full", full, 4'h0);
        check("reset_rd_data", rd_data, 4'h0);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            step(1'b1, five_words[i], 1'b0);
            check("w5_empty", empty, 4'h0);
            check("w5_full", full, 4'h0);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'h0, 1'b1);
            check("r5_data", rd_data, five_words[i]);
        end
        check("r5_empty_after", empty, 4'h1);

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'(i), 1'b0);
            check("fill_full", full, (i == 7) ? 4'h1 : 4'h0);
        end
        step(1'b1, 4'hE, 1'b0);
        check("drop_full", full, 4'h1);
        check("drop_rd_data_hold", rd_data, 4'hF);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'h0, 1'b1);
            check("drain8_data", rd_data, 4'(i));
            check("drain8_empty", empty, (i == 7) ? 4'h1 : 4'h0);
        end

        step(1'b1, 4'h5, 1'b0);
        step(1'b0, 4'h0, 1'b1);
        check("prep5_data", rd_data, 4'h5);
        step(1'b0, 4'h0, 1'b1);
        check("rd_empty_hold", rd_data, 4'h5);
        check("rd_empty_flag", empty, 4'h1);
        step(1'b0, 4'h0, 1'b1);
        check("rd_empty_hold2", rd_data, 4'h5);
        step(1'b1, 4'h9, 1'b0);
        check("after_empty_rd_count1", empty, 4'h0);
        step(1'b0, 4'h0, 1'b1);
        check("after_empty_rd_data", rd_data, 4'h9);
        check("after_empty_rd_empty", empty, 4'h1);

        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 4'(i), 1'b0);
        end
        check("full_before_rw", full, 4'h1);
        step(1'b1, 4'hC, 1'b1);
        check("full_rw_data", rd_data, 4'h1);
        check("full_rw_full", full, 4'h1);
        for (int i = 2; i <= 9; i++) begin
            step(1'b0, 4'h0, 1'b1);
            check("full_rw_drain", rd_data, (i == 9) ? 4'hC : 4'(i));
        end
        check("full_rw_drained", empty, 4'h1);

        step(1'b1, 4'h6, 1'b1);
        check("empty_rw_data_hold", rd_data, 4'hC);
        check("empty_rw_empty", empty, 4'h0);
        step(1'b0, 4'h0, 1'b1);
        check("empty_rw_read", rd_data, 4'h6);
        check("empty_rw_empty_after", empty, 4'h1);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'hA + 4'(i), 1'b0);
            q.push_back(4'hA + 4'(i));
        end
        for (int i = 0; i < 20; i++) begin
            w = ((i % 4) != 2);
            r = ((i % 4) != 0);
            d = 4'((i * 3 + 1) & 15);
            step(w, d, r);
            if (r) begin
                exp_word = q.pop_front();
                check("wrap_data", rd_data, exp_word);
            end
            if (w) begin
                q.push_back(d);
            end
            check("wrap_empty", empty, 4'h0);
        end
        while (q.size() > 0) begin
            step(1'b0, 4'h0, 1'b1);
            exp_word = q.pop_front();
            check("wrap_drain", rd_data, exp_word);
        end
        check("wrap_empty_end", empty, 4'h1);

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'h7 + 4'(i), 1'b0);
        end
        step(1'b0, 4'h0, 1'b1);
        check("midrst_pre_data", rd_data, 4'h7);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_empty", empty, 4'h1);
        check("midrst_full", full, 4'h0);
        check("midrst_rd_data", rd_data, 4'h0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        step(1'b1, 4'h4, 1'b0);
        check("post_rst_empty", empty, 4'h0);
        step(1'b0, 4'h0, 1'b1);
        check("post_rst_data", rd_data, 4'h4);
        check("post_rst_empty_after", empty, 4'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
